// File: rtl/wb_pkg.sv
// Shared types and constants for the ALU writeback unit: flag bit positions,
// ARM-style condition codes and the buffered entry layout.
package wb_pkg;

    localparam int FLAG_V = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 0;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    typedef struct packed {
        logic [31:0] rslt;
        logic [3:0]  flags;
        logic [4:0]  rd;
        logic [3:0]  cond;
        logic        set_flags;
    } wb_entry_t;

endpackage

// File: rtl/wb_cond_check.sv
// Combinational ARM-style condition evaluator: decides whether an instruction
// with condition code cond executes given the status flags {V,Z,C,N}.
module wb_cond_check
    import wb_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic w_v, w_z, w_c, w_n;

    assign w_v = flags[FLAG_V];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_n = flags[FLAG_N];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = w_z;
            COND_NE: pass = !w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = !w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = !w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = !w_v;
            COND_HI: pass = w_c && !w_z;
            COND_LS: pass = !w_c || w_z;
            COND_GE: pass = (w_n == w_v);
            COND_LT: pass = (w_n != w_v);
            COND_GT: pass = !w_z && (w_n == w_v);
            COND_LE: pass = w_z || (w_n != w_v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_unit.sv
// In-order writeback buffer between ALU and register file with conditional
// execution. Define WB_PERF_CNT_EN to add commit/annul performance counters.
module alu_writeback_unit
    import wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int R0_HARDWIRED = 0
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rslt,
    input  logic [3:0]  in_flags,
    input  logic [4:0]  in_rd,
    input  logic [3:0]  in_cond,
    input  logic        in_set_flags,
    input  logic        flush,
    input  logic        rf_busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
`ifdef WB_PERF_CNT_EN
    output logic [31:0] commit_cnt,
    output logic [31:0] annul_cnt,
`endif
    output logic [3:0]  flags_q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    wb_entry_t w_head;
    wb_entry_t w_in_entry;
    logic      w_push;
    logic      w_pop;
    logic      w_pass;
    logic      w_write;
    logic      w_r0_block;

    // in_ready depends only on occupancy, so a full buffer never accepts even
    // when the head commits on the same edge.
    assign in_ready   = (r_count != FULL_CNT);
    assign w_push     = in_valid && in_ready && !flush;
    assign w_pop      = (r_count != '0) && !rf_busy && !flush;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_in_entry = '{rslt: in_rslt, flags: in_flags, rd: in_rd,
                          cond: in_cond, set_flags: in_set_flags};

    wb_cond_check u_cond_check (
        .cond  (w_head.cond),
        .flags (flags_q),
        .pass  (w_pass)
    );

    assign w_r0_block = (R0_HARDWIRED != 0) && (w_head.rd == 5'd0);
    assign w_write    = w_pop && w_pass && !w_r0_block;

    always_ff @(posedge wb_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            flags_q  <= '0;
        end else begin
            rf_we <= w_write;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
            if (w_write) begin
                rf_waddr <= w_head.rd;
                rf_wdata <= w_head.rslt;
            end
            // Flags follow the condition, not the R0 suppression.
            if (w_pop && w_pass && w_head.set_flags) begin
                flags_q <= w_head.flags;
            end
        end
    end

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            commit_cnt <= '0;
            annul_cnt  <= '0;
        end else if (w_pop) begin
            if (w_pass) begin
                commit_cnt <= commit_cnt + 1'b1;
            end else begin
                annul_cnt <= annul_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Self-checking bench for alu_writeback_unit: a condition-code vector table
// plus hand-written backpressure, flush, R0 and reset sequences.
module tb_alu_writeback_unit;
    import wb_pkg::*;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_rslt = '0;
    logic [3:0]  in_flags = '0;
    logic [4:0]  in_rd = '0;
    logic [3:0]  in_cond = '0;
    logic        in_set_flags = 1'b0;
    logic        flush = 1'b0;
    logic        rf_busy = 1'b0;

    logic        in_ready0, rf_we0, in_ready1, rf_we1;
    logic [4:0]  rf_waddr0, rf_waddr1;
    logic [31:0] rf_wdata0, rf_wdata1;
    logic [3:0]  flags_q0, flags_q1;
`ifdef WB_PERF_CNT_EN
    logic [31:0] commit_cnt0, annul_cnt0, commit_cnt1, annul_cnt1;
`endif

    always #5 wb_clk = ~wb_clk;

    alu_writeback_unit #(.DEPTH(2), .R0_HARDWIRED(0)) u_dut0 (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_rslt(in_rslt), .in_flags(in_flags), .in_rd(in_rd), .in_cond(in_cond),
        .in_set_flags(in_set_flags), .flush(flush), .rf_busy(rf_busy), .rf_we(rf_we0),
        .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0),
`ifdef WB_PERF_CNT_EN
        .commit_cnt(commit_cnt0), .annul_cnt(annul_cnt0),
`endif
        .flags_q(flags_q0)
    );

    alu_writeback_unit #(.DEPTH(2), .R0_HARDWIRED(1)) u_dut1 (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_rslt(in_rslt), .in_flags(in_flags), .in_rd(in_rd), .in_cond(in_cond),
        .in_set_flags(in_set_flags), .flush(flush), .rf_busy(rf_busy), .rf_we(rf_we1),
        .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
`ifdef WB_PERF_CNT_EN
        .commit_cnt(commit_cnt1), .annul_cnt(annul_cnt1),
`endif
        .flags_q(flags_q1)
    );

    typedef struct {
        logic [3:0]  cond;
        logic [3:0]  flags;
        logic        set;
        logic [4:0]  rd;
        logic [31:0] rslt;
        logic        exp_we;
        logic [3:0]  exp_fq;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t vecs [18];
    wr_t  sb0 [$];
    wr_t  sb1 [$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Pops the matching scoreboard entry whenever a DUT writes the register file.
    task automatic monitor();
        wr_t e;
        if (rf_we0) begin
            $display("dut0 write rd=%0d data=0x%0h flags_q=%b", rf_waddr0, rf_wdata0, flags_q0);
            if (sb0.size() == 0) begin
                n_total++;
                $display("FAIL dut0_unexpected_write: got rf_we=1 rd=%0d, expected no write", rf_waddr0);
            end else begin
                e = sb0.pop_front();
                check("dut0_waddr", 32'(rf_waddr0), 32'(e.a));
                check("dut0_wdata", rf_wdata0, e.d);
            end
        end
        if (rf_we1) begin
            $display("dut1 write rd=%0d data=0x%0h flags_q=%b", rf_waddr1, rf_wdata1, flags_q1);
            if (sb1.size() == 0) begin
                n_total++;
                $display("FAIL dut1_unexpected_write: got rf_we=1 rd=%0d, expected no write", rf_waddr1);
            end else begin
                e = sb1.pop_front();
                check("dut1_waddr", 32'(rf_waddr1), 32'(e.a));
                check("dut1_wdata", rf_wdata1, e.d);
            end
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
        monitor();
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] f, input logic s,
                         input logic [4:0] rd, input logic [31:0] r);
        in_valid = 1'b1; in_cond = c; in_flags = f; in_set_flags = s; in_rd = rd; in_rslt = r;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input logic dut1_too);
        sb0.push_back('{a: a, d: d});
        if (dut1_too) sb1.push_back('{a: a, d: d});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{COND_AL, 4'b0000, 1'b1, 5'd3,  32'h0000_0005, 1'b1, 4'b0000};
        vecs[1]  = '{COND_AL, 4'b0100, 1'b1, 5'd1,  32'h0000_0000, 1'b1, 4'b0100};
        vecs[2]  = '{COND_EQ, 4'b0000, 1'b0, 5'd4,  32'h0000_00AA, 1'b1, 4'b0100};
        vecs[3]  = '{COND_NE, 4'b0000, 1'b1, 5'd5,  32'h0000_0055, 1'b0, 4'b0100};
        vecs[4]  = '{COND_LS, 4'b0010, 1'b1, 5'd6,  32'h0000_0011, 1'b1, 4'b0010};
        vecs[5]  = '{COND_HI, 4'b1001, 1'b1, 5'd7,  32'h0000_0022, 1'b1, 4'b1001};
        vecs[6]  = '{COND_GE, 4'b0001, 1'b1, 5'd8,  32'h0000_0033, 1'b1, 4'b0001};
        vecs[7]  = '{COND_GE, 4'b0000, 1'b1, 5'd9,  32'h0000_0034, 1'b0, 4'b0001};
        vecs[8]  = '{COND_LT, 4'b0000, 1'b0, 5'd10, 32'h0000_0044, 1'b1, 4'b0001};
        vecs[9]  = '{COND_MI, 4'b0000, 1'b1, 5'd11, 32'h0000_0066, 1'b1, 4'b0000};
        vecs[10] = '{COND_GT, 4'b1000, 1'b1, 5'd12, 32'h0000_0077, 1'b1, 4'b1000};
        vecs[11] = '{COND_VS, 4'b0110, 1'b1, 5'd13, 32'hCAFE_0013, 1'b1, 4'b0110};
        vecs[12] = '{COND_LE, 4'b0000, 1'b0, 5'd14, 32'h0000_0088, 1'b1, 4'b0110};
        vecs[13] = '{COND_NV, 4'b1111, 1'b1, 5'd15, 32'hFFFF_FFFF, 1'b0, 4'b0110};
        vecs[14] = '{COND_CS, 4'b0000, 1'b1, 5'd16, 32'h1234_5678, 1'b1, 4'b0000};
        vecs[15] = '{COND_CC, 4'b0001, 1'b1, 5'd17, 32'h8765_4321, 1'b1, 4'b0001};
        vecs[16] = '{COND_PL, 4'b0000, 1'b1, 5'd18, 32'h0000_0018, 1'b0, 4'b0001};
        vecs[17] = '{COND_VC, 4'b0000, 1'b1, 5'd0,  32'h0000_0099, 1'b1, 4'b0000};

        // Reset values
        tick();
        check("rst_ready", 32'(in_ready0), 32'd1);
        check("rst_we", 32'(rf_we0), 32'd0);
        check("rst_waddr", 32'(rf_waddr0), 32'd0);
        check("rst_flags", 32'(flags_q0), 32'd0);
        tick();
        wb_rst_n = 1'b1;
        tick();

        // Condition-code table, one instruction at a time
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].cond, vecs[i].flags, vecs[i].set, vecs[i].rd, vecs[i].rslt);
            if (vecs[i].exp_we) expect_wr(vecs[i].rd, vecs[i].rslt, vecs[i].rd != 5'd0);
            tick();
            in_valid = 1'b0;
            if (i == 0) check("enq_no_same_edge_commit", 32'(rf_we0), 32'd0);
            tick();
            check($sformatf("vec%0d_we", i), 32'(rf_we0), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_flags", i), 32'(flags_q0), 32'(vecs[i].exp_fq));
            if (i == 0) begin
                tick();
                check("basic_we_drop", 32'(rf_we0), 32'd0);
            end
        end

        // Backpressure: third beat held while full, then three back-to-back commits
        rf_busy = 1'b1;
        drive(COND_AL, 4'b0000, 1'b0, 5'd1, 32'h0000_0101);
        check("bp_ready_0", 32'(in_ready0), 32'd1);
        tick();
        drive(COND_AL, 4'b0000, 1'b0, 5'd2, 32'h0000_0102);
        check("bp_ready_1", 32'(in_ready0), 32'd1);
        tick();
        drive(COND_AL, 4'b0101, 1'b1, 5'd3, 32'h0000_0103);
        check("bp_full_0", 32'(in_ready0), 32'd0);
        tick();
        check("bp_full_1", 32'(in_ready0), 32'd0);
        tick();
        check("bp_full_2", 32'(in_ready0), 32'd0);
        check("bp_no_we", 32'(rf_we0), 32'd0);
        expect_wr(5'd1, 32'h0000_0101, 1'b1);
        expect_wr(5'd2, 32'h0000_0102, 1'b1);
        expect_wr(5'd3, 32'h0000_0103, 1'b1);
        rf_busy = 1'b0;
        tick();
        check("bp_we_a", 32'(rf_we0), 32'd1);
        check("bp_addr_a", 32'(rf_waddr0), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_we_b", 32'(rf_we0), 32'd1);
        check("bp_addr_b", 32'(rf_waddr0), 32'd2);
        tick();
        check("bp_we_c", 32'(rf_we0), 32'd1);
        check("bp_addr_c", 32'(rf_waddr0), 32'd3);
        check("bp_flags", 32'(flags_q0), 32'b0101);
        tick();
        check("bp_we_idle", 32'(rf_we0), 32'd0);
        check("bp_hold_data", rf_wdata0, 32'h0000_0103);

        // Flush with two entries buffered and a beat offered
        rf_busy = 1'b1;
        drive(COND_AL, 4'b1010, 1'b1, 5'd20, 32'h0000_0201);
        tick();
        drive(COND_AL, 4'b1010, 1'b1, 5'd21, 32'h0000_0202);
        tick();
        drive(COND_AL, 4'b1010, 1'b1, 5'd22, 32'h0000_0203);
        flush = 1'b1;
        rf_busy = 1'b0;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_we_0", 32'(rf_we0), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("flush_we_%0d", k), 32'(rf_we0), 32'd0);
        end
        check("flush_flags", 32'(flags_q0), 32'b0101);
        rf_busy = 1'b1;
        drive(COND_AL, 4'b0000, 1'b0, 5'd23, 32'h0000_0301);
        check("flush_empty_ready_0", 32'(in_ready0), 32'd1);
        tick();
        drive(COND_AL, 4'b0000, 1'b0, 5'd24, 32'h0000_0302);
        check("flush_empty_ready_1", 32'(in_ready0), 32'd1);
        tick();
        in_valid = 1'b0;
        check("flush_refill_full", 32'(in_ready0), 32'd0);
        expect_wr(5'd23, 32'h0000_0301, 1'b1);
        expect_wr(5'd24, 32'h0000_0302, 1'b1);
        rf_busy = 1'b0;
        tick();
        tick();
        tick();

        // R0 hardwired: write suppressed, flags still updated
        drive(COND_AL, 4'b1000, 1'b1, 5'd0, 32'h0000_DEAD);
        expect_wr(5'd0, 32'h0000_DEAD, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("r0_dut0_we", 32'(rf_we0), 32'd1);
        check("r0_dut1_we", 32'(rf_we1), 32'd0);
        check("r0_dut1_flags", 32'(flags_q1), 32'b1000);
        check("r0_dut0_flags", 32'(flags_q0), 32'b1000);
        tick();

        // Asynchronous reset mid-stream with a write in flight
        rf_busy = 1'b1;
        drive(COND_AL, 4'b1111, 1'b1, 5'd25, 32'h0000_0401);
        tick();
        drive(COND_AL, 4'b1111, 1'b1, 5'd26, 32'h0000_0402);
        tick();
        in_valid = 1'b0;
        expect_wr(5'd25, 32'h0000_0401, 1'b1);
        rf_busy = 1'b0;
        tick();
        check("prerst_we", 32'(rf_we0), 32'd1);
        check("prerst_flags", 32'(flags_q0), 32'b1111);
        #2;
        wb_rst_n = 1'b0;
        #1;
        check("arst_we", 32'(rf_we0), 32'd0);
        check("arst_flags", 32'(flags_q0), 32'd0);
        check("arst_ready", 32'(in_ready0), 32'd1);
        check("arst_waddr", 32'(rf_waddr0), 32'd0);
        check("arst_wdata", rf_wdata0, 32'd0);
        tick();
        tick();
        wb_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("postrst_we_%0d", k), 32'(rf_we0), 32'd0);
        end
        check("postrst_ready", 32'(in_ready0), 32'd1);

        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
